bypass_sel_gen: RTL and testbench

//  Tracks destination-register tags of the 4 issue lanes across the two result stages (EX, MEM).
//  For one source operand, generates the 4-bit select for the 9-input forwarding mux.

---
 rtl/bypass_sel_gen.sv | 70 +++++++
 tb/tb_bypass_sel_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bypass_sel_gen.sv
// bypass_sel_gen: per-operand forwarding-mux select and load-use hazard from EX/MEM destination tags (optional stats under BYPASS_STATS_EN)
module bypass_sel_gen #(
  parameter int REGW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        iss_wr,
  input  logic [3:0]        iss_ld,
  input  logic [4*REGW-1:0] iss_dst,
  input  logic [REGW-1:0]   src_reg,
  input  logic              src_rd,
  output logic [3:0]        sel,
  output logic              ld_hazard
`ifdef BYPASS_STATS_EN
  ,
  output logic [31:0]       fwd_cnt,
  output logic [31:0]       hz_cnt
`endif
);
  logic [3:0] ex_v, ex_ld, mem_v, ex_hit, mem_hit;
  logic [4*REGW-1:0] ex_dst, mem_dst;
  logic ld_win;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v <= '0;
      ex_ld <= '0;
      mem_v <= '0;
      ex_dst <= '0;
      mem_dst <= '0;
    end else if (flush) begin
      ex_v <= '0;
      ex_ld <= '0;
      mem_v <= '0;
    end else if (!stall) begin
      ex_v <= iss_wr;
      ex_ld <= iss_ld;
      ex_dst <= iss_dst;
      mem_v <= ex_v;
      mem_dst <= ex_dst;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_hit
    assign ex_hit[i] = (src_reg != '0) && ex_v[i] && (ex_dst[i*REGW +: REGW] == src_reg);
    assign mem_hit[i] = (src_reg != '0) && mem_v[i] && (mem_dst[i*REGW +: REGW] == src_reg);
  end
  // ascending scan lets younger lanes and the EX stage overwrite older winners
  always_comb begin
    sel = '0;
    ld_win = 1'b0;
    for (int j = 0; j < 4; j++) sel = mem_hit[j] ? 4'(5 + j) : sel;
    for (int j = 0; j < 4; j++) begin
      sel = ex_hit[j] ? 4'(1 + j) : sel;
      ld_win = ex_hit[j] ? ex_ld[j] : ld_win;
    end
  end
  assign ld_hazard = src_rd && ld_win;
`ifdef BYPASS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt <= '0;
      hz_cnt <= '0;
    end else begin
      fwd_cnt <= fwd_cnt + 32'(src_rd && sel != '0 && !stall);
      hz_cnt <= hz_cnt + 32'(ld_hazard);
    end
  end
`endif
endmodule

// File: tb/tb_bypass_sel_gen.sv
// tb_bypass_sel_gen: directed plan plus random traffic against a bundle-level reference model
module tb_bypass_sel_gen;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, src_rd = 1'b0;
  logic [3:0] iss_wr = '0, iss_ld = '0, sel;
  logic [19:0] iss_dst = '0;
  logic [4:0] src_reg = '0;
  logic ld_hazard;
  int total = 0, bad = 0;
  typedef struct {logic v; logic ld; logic [4:0] dst;} tag_t;
  tag_t m_ex[4], m_mem[4];
  logic [31:0] m_fwd = 0, m_hz = 0;
`ifdef BYPASS_STATS_EN
  logic [31:0] fwd_cnt, hz_cnt;
`endif
  bypass_sel_gen #(.REGW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .iss_wr(iss_wr), .iss_ld(iss_ld), .iss_dst(iss_dst),
    .src_reg(src_reg), .src_rd(src_rd), .sel(sel), .ld_hazard(ld_hazard)
`ifdef BYPASS_STATS_EN
    , .fwd_cnt(fwd_cnt), .hz_cnt(hz_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic void model_out(output logic [3:0] s, output logic h);
    s = 0;
    h = 0;
    if (src_reg == 0) return;
    for (int l = 3; l >= 0; l--)
      if (m_ex[l].v && m_ex[l].dst == src_reg) begin
        s = 4'(1 + l);
        h = src_rd && m_ex[l].ld;
        return;
      end
    for (int l = 3; l >= 0; l--)
      if (m_mem[l].v && m_mem[l].dst == src_reg) begin
        s = 4'(5 + l);
        return;
      end
  endfunction
  task automatic tick();
    logic [3:0] s;
    logic h;
    @(posedge clk);
    model_out(s, h);
    if (reset) begin
      m_fwd = 0;
      m_hz = 0;
    end else begin
      if (src_rd && s != 0 && !stall) m_fwd++;
      if (h) m_hz++;
    end
    for (int l = 0; l < 4; l++)
      if (reset || flush) begin
        m_ex[l].v = 0;
        m_mem[l].v = 0;
      end else if (!stall) begin
        m_mem[l] = '{m_ex[l].v, 1'b0, m_ex[l].dst};
        m_ex[l] = '{iss_wr[l], iss_ld[l], iss_dst[l*5 +: 5]};
      end
    #1;
  endtask
  task automatic issue(input logic [3:0] wr, input logic [3:0] ld, input logic [4:0] r);
    iss_wr = wr;
    iss_ld = ld;
    iss_dst = {4{r}};
  endtask
  task automatic chk(input string tag);
    logic [3:0] s;
    logic h;
    #1;
    model_out(s, h);
    total++;
    assert (sel === s) else begin bad++; $error("FAIL %s sel got=%0d want=%0d", tag, sel, s); end
    total++;
    assert (ld_hazard === h) else begin bad++; $error("FAIL %s ld_hazard got=%0b want=%0b", tag, ld_hazard, h); end
`ifdef BYPASS_STATS_EN
    total++;
    assert (fwd_cnt === m_fwd) else begin bad++; $error("FAIL %s fwd_cnt got=%0d want=%0d", tag, fwd_cnt, m_fwd); end
    total++;
    assert (hz_cnt === m_hz) else begin bad++; $error("FAIL %s hz_cnt got=%0d want=%0d", tag, hz_cnt, m_hz); end
`endif
  endtask
  task automatic req(input string tag, input logic [3:0] s, input logic h);
    chk(tag);
    total++;
    assert (sel === s) else begin bad++; $error("FAIL %s req sel got=%0d want=%0d", tag, sel, s); end
    total++;
    assert (ld_hazard === h) else begin bad++; $error("FAIL %s req ld_hazard got=%0b want=%0b", tag, ld_hazard, h); end
  endtask
  initial begin
    for (int l = 0; l < 4; l++) begin
      m_ex[l] = '{0, 0, 0};
      m_mem[l] = '{0, 0, 0};
    end
    issue(4'hF, 4'h0, 5'd7);
    src_reg = 7;
    src_rd = 1;
    tick();
    tick();
    reset = 0;
    issue(0, 0, 0);
    req("t1_reset", 0, 0);
`ifdef BYPASS_STATS_EN
    total++;
    assert (fwd_cnt === 0 && hz_cnt === 0) else begin bad++; $error("FAIL t1_cnt got=%0d/%0d want=0/0", fwd_cnt, hz_cnt); end
`endif
    issue(4'b0100, 0, 5'd5);
    src_reg = 5;
    tick();
    issue(0, 0, 0);
    req("t2_ex", 3, 0);
    tick();
    req("t2_mem", 7, 0);
    tick();
    req("t2_gone", 0, 0);
    issue(4'b1001, 0, 5'd9);
    src_reg = 9;
    tick();
    issue(0, 0, 0);
    req("t3_ex", 4, 0);
    tick();
    req("t3_mem", 8, 0);
    issue(4'b1001, 0, 5'd9);
    tick();
    issue(4'b0010, 0, 5'd9);
    tick();
    issue(0, 0, 0);
    req("t3_ex_over_mem", 2, 0);
    tick();
    req("t3_mem_l1", 6, 0);
    issue(4'b0001, 4'b0001, 5'd4);
    src_reg = 4;
    tick();
    issue(0, 0, 0);
    req("t4_hz", 1, 1);
    stall = 1;
    tick();
    req("t4_stall1", 1, 1);
    tick();
    req("t4_stall2", 1, 1);
    stall = 0;
    tick();
    req("t4_release", 5, 0);
    src_rd = 0;
    req("t4_mem_nord", 5, 0);
    issue(4'b0001, 4'b0001, 5'd4);
    tick();
    issue(0, 0, 0);
    req("t4_nord", 1, 0);
    src_rd = 1;
    issue(4'b0101, 4'b0001, 5'd4);
    tick();
    issue(0, 0, 0);
    req("t4_mask", 3, 0);
    issue(4'b1010, 4'b1000, 5'd4);
    tick();
    issue(0, 0, 0);
    req("t4_young_ld", 4, 1);
    issue(4'hF, 4'hF, 5'd0);
    src_reg = 0;
    tick();
    issue(0, 0, 0);
    req("t5_r0", 0, 0);
    issue(4'b0001, 0, 5'd3);
    src_reg = 3;
    tick();
    tick();
    req("t5_pre", 1, 0);
    flush = 1;
    stall = 1;
    tick();
    flush = 0;
    stall = 0;
    issue(0, 0, 0);
    req("t5_flush", 0, 0);
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(63) == 0);
      flush = ($urandom_range(15) == 0);
      stall = ($urandom_range(3) == 0);
      iss_wr = 4'($urandom);
      iss_ld = 4'($urandom);
      for (int l = 0; l < 4; l++) iss_dst[l*5 +: 5] = 5'($urandom_range(7));
      src_reg = 5'($urandom_range(7));
      src_rd = 1'($urandom);
      chk("rand");
      tick();
    end
    reset = 0;
    chk("rand_end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
